// File: rtl/mem_block_mover.sv
// mem_block_mover: copies or fills a run of RAM words, reporting a checksum and a done pulse
module mem_block_mover #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_src_addr,
  input  logic [ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  input  logic [DATA_WIDTH-1:0] i_fill_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_checksum,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_q
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] L_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] L_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  state_t                r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   w_len;
  // clamp the requested word count to the size of the address space
  always_comb w_len = (i_length > L_MAX) ? L_MAX : i_length;
  // transfer FSM; RAM-facing outputs are registered for the state being entered,
  // and o_ram_data doubles as the word buffer in copy mode and the fill constant in fill mode
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_checksum <= '0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
      o_ram_we   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_mode     <= i_mode;
          r_src      <= i_src_addr;
          r_dst      <= i_dst_addr;
          r_cnt      <= w_len;
          o_checksum <= '0;
          if (w_len == '0) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end else if (!i_mode) begin
            r_state    <= S_READ;
            o_busy     <= 1'b1;
            o_ram_addr <= i_src_addr;
          end else begin
            r_state    <= S_WRITE;
            o_busy     <= 1'b1;
            o_ram_we   <= 1'b1;
            o_ram_addr <= i_dst_addr;
            o_ram_data <= i_fill_value;
          end
        end
        S_READ: begin
          r_state    <= S_WRITE;
          r_src      <= r_src + 1'b1;
          o_ram_data <= i_ram_q;
          o_ram_addr <= r_dst;
          o_ram_we   <= 1'b1;
        end
        S_WRITE: begin
          o_checksum <= o_checksum + o_ram_data;
          r_dst      <= r_dst + 1'b1;
          r_cnt      <= r_cnt - L_ONE;
          if (r_cnt == L_ONE) begin
            r_state  <= S_DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_ram_we <= 1'b0;
          end else if (!r_mode) begin
            r_state    <= S_READ;
            o_ram_we   <= 1'b0;
            o_ram_addr <= r_src;
          end else begin
            o_ram_addr <= r_dst + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
